// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: MMIO address map, responder state encoding and the shared
// ready-bit position used by KBSR and DSR.
package lc3_mem_pkg;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

   localparam int unsigned RDY_BIT = 15;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StReady
   } state_e;

   // Status word with only the ready bit populated.
   function automatic logic [15:0] rdy_word(input logic rdy);
      logic [15:0] w;
      w          = '0;
      w[RDY_BIT] = rdy;
      return w;
   endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if: LC-3 MAR/MDR memory handshake between core (master)
// and memory responder (slave).
interface lc3_mem_responder_if;

   logic        mem_en;
   logic        r_w;
   logic [15:0] addr;
   logic [15:0] d_in;
   logic [15:0] d_out;
   logic        ready;

   modport master (
      output mem_en, r_w, addr, d_in,
      input  d_out, ready
   );

   modport slave (
      input  mem_en, r_w, addr, d_in,
      output d_out, ready
   );

endinterface

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard (KBSR/KBDR), display (DSR/DDR) and machine control
// (MCR) registers. Address decode and commit timing come from the top.
module lc3_mmio_regs #(
   parameter int unsigned DISP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbdr_rd,
   input  logic       ddr_wr,
   input  logic       mcr_wr,
   input  logic [7:0] wr_byte,
   input  logic       wr_msb,
   input  logic       kb_strobe,
   input  logic [7:0] kb_data,
   output logic       kb_rdy,
   output logic [7:0] kbdr,
   output logic       dsr_rdy,
   output logic       ddr_valid,
   output logic [7:0] ddr_data,
   output logic       run
);

   localparam int unsigned CntW    = $clog2(DISP_CYCLES + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(DISP_CYCLES);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic            kb_rdy_q;
   logic [7:0]      kbdr_q;
   logic            dsr_rdy_q;
   logic [CntW-1:0] disp_cnt_q;
   logic            ddr_valid_q;
   logic [7:0]      ddr_data_q;
   logic            run_q;
   logic            ddr_accept;

   // A DDR write only lands while the display is idle; otherwise it is dropped.
   assign ddr_accept = ddr_wr && dsr_rdy_q;

   // Keyboard capture; a new strobe wins over a concurrent KBDR read clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kb_rdy_q <= 1'b0;
         kbdr_q   <= '0;
      end else if (kb_strobe) begin
         kb_rdy_q <= 1'b1;
         kbdr_q   <= kb_data;
      end else if (kbdr_rd) begin
         kb_rdy_q <= 1'b0;
      end
   end

   // Display output: accept a character, then hold DSR busy for DISP_CYCLES.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dsr_rdy_q   <= 1'b1;
         disp_cnt_q  <= '0;
         ddr_valid_q <= 1'b0;
         ddr_data_q  <= '0;
      end else begin
         ddr_valid_q <= ddr_accept;
         if (ddr_accept) begin
            ddr_data_q <= wr_byte;
            dsr_rdy_q  <= 1'b0;
            disp_cnt_q <= CntLoad;
         end else if (disp_cnt_q != '0) begin
            disp_cnt_q <= disp_cnt_q - CntOne;
            if (disp_cnt_q == CntOne) dsr_rdy_q <= 1'b1;
         end
      end
   end

   // Machine control: only the run bit is implemented.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        run_q <= 1'b1;
      else if (mcr_wr) run_q <= wr_msb;
   end

   assign kb_rdy    = kb_rdy_q;
   assign kbdr      = kbdr_q;
   assign dsr_rdy   = dsr_rdy_q;
   assign ddr_valid = ddr_valid_q;
   assign ddr_data  = ddr_data_q;
   assign run       = run_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 memory-side responder with wait-state FSM, program
// RAM and MMIO decode. Optional sticky unmapped-access flag: LC3_MEM_ERR_EN.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [15:0] MEM_BASE    = 16'h3000,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DISP_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   lc3_mem_responder_if.slave  bus,
   input  logic                kb_strobe,
   input  logic [7:0]          kb_data,
   output logic                ddr_valid,
   output logic [7:0]          ddr_data,
   output logic                run,
   output logic                mem_err
);

   localparam int unsigned Depth   = 2 ** ADDR_W;
   localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
   localparam logic [16:0] WinLo   = {1'b0, MEM_BASE};
   localparam logic [16:0] WinHi   = WinLo + 17'(Depth);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              accept, commit;
   logic              wr_q;
   logic [15:0]       addr_q, wdata_q;
   logic              acc_wr;
   logic [15:0]       acc_addr, acc_wdata;
   logic              sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;
   logic              mmio_hit, in_window, ram_hit;
   logic [ADDR_W-1:0] ram_idx;
   logic [15:0]       mem [Depth];
   logic [15:0]       rdata, d_out_q;
   logic              kb_rdy, dsr_rdy;
   logic [7:0]        kbdr;

   // State register, wait counter and request latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= bus.r_w;
            addr_q  <= bus.addr;
            wdata_q <= bus.d_in;
         end
      end
   end

   // Next state; commit marks the edge that enters READY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.mem_en) begin
               accept = 1'b1;
               cnt_d  = CntInit;
               if (LATENCY == 1) begin
                  state_d = StReady;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StReady;
               commit  = 1'b1;
            end
         end
         StReady: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // With single-cycle latency the commit edge is the acceptance edge, so the
   // live request is used there instead of the latch.
   assign acc_addr  = (state_q == StIdle) ? bus.addr : addr_q;
   assign acc_wr    = (state_q == StIdle) ? bus.r_w  : wr_q;
   assign acc_wdata = (state_q == StIdle) ? bus.d_in : wdata_q;

   // Address decode; MMIO shadows RAM.
   always_comb begin
      sel_kbsr  = (acc_addr == KBSR_ADDR);
      sel_kbdr  = (acc_addr == KBDR_ADDR);
      sel_dsr   = (acc_addr == DSR_ADDR);
      sel_ddr   = (acc_addr == DDR_ADDR);
      sel_mcr   = (acc_addr == MCR_ADDR);
      mmio_hit  = sel_kbsr || sel_kbdr || sel_dsr || sel_ddr || sel_mcr;
      in_window = ({1'b0, acc_addr} >= WinLo) && ({1'b0, acc_addr} < WinHi);
      ram_hit   = in_window && !mmio_hit;
      ram_idx   = ADDR_W'(acc_addr - MEM_BASE);
   end

   // Read data mux; unmapped addresses read as zero.
   always_comb begin
      rdata = '0;
      if (sel_kbsr)     rdata = rdy_word(kb_rdy);
      else if (sel_kbdr) rdata = {8'h00, kbdr};
      else if (sel_dsr)  rdata = rdy_word(dsr_rdy);
      else if (sel_ddr)  rdata = {8'h00, ddr_data};
      else if (sel_mcr)  rdata = rdy_word(run);
      else if (ram_hit)  rdata = mem[ram_idx];
   end

   // Program RAM write port; contents survive reset, rst gates stray commits.
   always_ff @(posedge clk) begin
      if (rst && commit && acc_wr && ram_hit) mem[ram_idx] <= acc_wdata;
   end

   // Read capture; d_out holds until the next read completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  d_out_q <= '0;
      else if (commit && !acc_wr) d_out_q <= rdata;
   end

   lc3_mmio_regs #(
      .DISP_CYCLES (DISP_CYCLES)
   ) u_mmio (
      .clk       (clk),
      .rst       (rst),
      .kbdr_rd   (commit && !acc_wr && sel_kbdr),
      .ddr_wr    (commit && acc_wr && sel_ddr),
      .mcr_wr    (commit && acc_wr && sel_mcr),
      .wr_byte   (acc_wdata[7:0]),
      .wr_msb    (acc_wdata[RDY_BIT]),
      .kb_strobe (kb_strobe),
      .kb_data   (kb_data),
      .kb_rdy    (kb_rdy),
      .kbdr      (kbdr),
      .dsr_rdy   (dsr_rdy),
      .ddr_valid (ddr_valid),
      .ddr_data  (ddr_data),
      .run       (run)
   );

   assign bus.d_out = d_out_q;
   assign bus.ready = (state_q == StReady);

`ifdef LC3_MEM_ERR_EN
   logic unmapped;
   logic mem_err_q;

   assign unmapped = !mmio_hit && !in_window;

   // Sticky unmapped-access flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     mem_err_q <= 1'b0;
      else if (commit && unmapped) mem_err_q <= 1'b1;
   end

   assign mem_err = mem_err_q;
`else
   assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed plus randomized transactions checked against a
// transaction-level model of the LC-3 memory map.
module tb_lc3_mem_responder;

   localparam int unsigned AddrW   = 10;
   localparam int unsigned MemBase = 'h3000;
   localparam int unsigned Lat     = 2;
   localparam int unsigned Disp    = 8;
`ifdef LC3_MEM_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       kb_strobe;
   logic [7:0] kb_data;
   logic       ddr_valid;
   logic [7:0] ddr_data;
   logic       run;
   logic       mem_err;

   lc3_mem_responder_if bus_if ();

   lc3_mem_responder #(
      .ADDR_W      (AddrW),
      .MEM_BASE    (16'(MemBase)),
      .LATENCY     (Lat),
      .DISP_CYCLES (Disp)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .kb_strobe (kb_strobe),
      .kb_data   (kb_data),
      .ddr_valid (ddr_valid),
      .ddr_data  (ddr_data),
      .run       (run),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model state.
   logic [15:0] ram_m [int];
   bit          kb_full;
   logic [7:0]  kb_char;
   bit          run_m;
   logic [7:0]  ddr_m;
   bit          err_m;
   int unsigned disp_free;  // first commit edge at which the display is idle

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [15:0] a);
      return int'(a) >= int'(MemBase) && int'(a) < int'(MemBase) + (1 << AddrW);
   endfunction

   function automatic bit is_mmio(input logic [15:0] a);
      return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06 || a == 16'hFFFE;
   endfunction

   function automatic void model_reset();
      kb_full   = 1'b0;
      kb_char   = 8'h00;
      run_m     = 1'b1;
      ddr_m     = 8'h00;
      err_m     = 1'b0;
      disp_free = 0;
   endfunction

   function automatic logic [15:0] ref_read(input logic [15:0] a, input int unsigned e);
      case (a)
         16'hFE00: return kb_full ? 16'h8000 : 16'h0000;
         16'hFE02: return {8'h00, kb_char};
         16'hFE04: return (e >= disp_free) ? 16'h8000 : 16'h0000;
         16'hFE06: return {8'h00, ddr_m};
         16'hFFFE: return run_m ? 16'h8000 : 16'h0000;
         default: begin
            if (in_win(a) && ram_m.exists(int'(a))) return ram_m[int'(a)];
            return 16'h0000;
         end
      endcase
   endfunction

   function automatic void ref_commit(input logic wr, input logic [15:0] a, input logic [15:0] d,
                                      input int unsigned e, input bit fired, input logic [7:0] ch);
      if (wr) begin
         if (a == 16'hFE06) begin
            if (e >= disp_free) begin
               ddr_m     = d[7:0];
               disp_free = e + Disp + 1;
            end
         end else if (a == 16'hFFFE) begin
            run_m = d[15];
         end else if (!is_mmio(a) && in_win(a)) begin
            ram_m[int'(a)] = d;
         end
      end else if (a == 16'hFE02) begin
         kb_full = 1'b0;
      end
      if (ErrEn && !is_mmio(a) && !in_win(a)) err_m = 1'b1;
      if (fired) begin
         kb_full = 1'b1;
         kb_char = ch;
      end
   endfunction

   task automatic kb_pulse(input logic [7:0] ch);
      @(negedge clk);
      kb_strobe = 1'b1;
      kb_data   = ch;
      @(posedge clk);
      #1;
      kb_strobe = 1'b0;
      kb_full   = 1'b1;
      kb_char   = ch;
   endtask

   // One complete access, checking latency, pulse width, data and side outputs.
   task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            input bit strobe_at_commit, input logic [7:0] ch);
      int unsigned ce;
      logic [15:0] exp_rd;
      bit          exp_valid;
      bit          fired;
      fired = 1'b0;
      @(negedge clk);
      bus_if.mem_en = 1'b1;
      bus_if.r_w    = wr;
      bus_if.addr   = a;
      bus_if.d_in   = d;
      @(posedge clk);
      #1;
      ce = cyc + Lat - 1;
      bus_if.mem_en = 1'b0;
      bus_if.r_w    = 1'($urandom);
      bus_if.addr   = 16'($urandom);
      bus_if.d_in   = 16'($urandom);
      for (int i = 1; i < int'(Lat); i++) begin
         if (i == int'(Lat) - 1 && strobe_at_commit) begin
            @(negedge clk);
            kb_strobe = 1'b1;
            kb_data   = ch;
            fired     = 1'b1;
         end
         @(posedge clk);
         #1;
         kb_strobe = 1'b0;
         if (i < int'(Lat) - 1) check_val("ready_early", 16'(bus_if.ready), 16'h0);
      end
      exp_rd    = ref_read(a, ce);
      exp_valid = wr && a == 16'hFE06 && ce >= disp_free;
      check_val("ready_pulse", 16'(bus_if.ready), 16'h1);
      if (!wr) check_val("d_out", bus_if.d_out, exp_rd);
      check_val("ddr_valid", 16'(ddr_valid), 16'(exp_valid));
      ref_commit(wr, a, d, ce, fired, ch);
      check_val("ddr_data", 16'(ddr_data), 16'(ddr_m));
      check_val("run", 16'(run), 16'(run_m));
      check_val("mem_err", 16'(mem_err), 16'(err_m));
      @(posedge clk);
      #1;
      check_val("ready_width", 16'(bus_if.ready), 16'h0);
      check_val("ddr_valid_width", 16'(ddr_valid), 16'h0);
   endtask

   // mem_en held high across two reads: two pulses with one IDLE cycle between.
   task automatic hold_reads(input logic [15:0] a0, input logic [15:0] a1);
      logic [15:0] e0, e1;
      e0 = ref_read(a0, 0);
      e1 = ref_read(a1, 0);
      @(negedge clk);
      bus_if.mem_en = 1'b1;
      bus_if.r_w    = 1'b0;
      bus_if.addr   = a0;
      for (int off = 0; off <= 2 * int'(Lat) + 1; off++) begin
         @(posedge clk);
         #1;
         if (off == 0) bus_if.addr = a1;
         if (off == int'(Lat) + 1) bus_if.mem_en = 1'b0;
         check_val("hold_ready", 16'(bus_if.ready),
                   16'(off == int'(Lat) - 1 || off == 2 * int'(Lat)));
         if (off == int'(Lat) - 1) check_val("hold_d0", bus_if.d_out, e0);
         if (off == 2 * int'(Lat)) check_val("hold_d1", bus_if.d_out, e1);
      end
   endtask

   // Reset asserted while a RAM write is still waiting.
   task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      bus_if.mem_en = 1'b1;
      bus_if.r_w    = 1'b1;
      bus_if.addr   = a;
      bus_if.d_in   = d;
      @(posedge clk);
      #1;
      bus_if.mem_en = 1'b0;
      if (Lat == 1) ram_m[int'(a)] = d;
      rst = 1'b0;
      #1;
      model_reset();
      check_val("rst_ready", 16'(bus_if.ready), 16'h0);
      check_val("rst_run", 16'(run), 16'h1);
      check_val("rst_d_out", bus_if.d_out, 16'h0);
      check_val("rst_ddr_data", 16'(ddr_data), 16'h0);
      check_val("rst_mem_err", 16'(mem_err), 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] a, d;
      int unsigned op;
      rst           = 1'b0;
      bus_if.mem_en = 1'b0;
      bus_if.r_w    = 1'b0;
      bus_if.addr   = '0;
      bus_if.d_in   = '0;
      kb_strobe     = 1'b0;
      kb_data       = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_ready", 16'(bus_if.ready), 16'h0);
      check_val("reset_d_out", bus_if.d_out, 16'h0);
      check_val("reset_ddr_valid", 16'(ddr_valid), 16'h0);
      check_val("reset_ddr_data", 16'(ddr_data), 16'h0);
      check_val("reset_run", 16'(run), 16'h1);
      check_val("reset_mem_err", 16'(mem_err), 16'h0);
      @(negedge clk);
      rst = 1'b1;

      // Basic write then read.
      do_access(1'b1, 16'h3005, 16'h1234, 1'b0, 8'h00);
      do_access(1'b0, 16'h3005, 16'h0000, 1'b0, 8'h00);
      check_val("t1_value", bus_if.d_out, 16'h1234);

      // Back-to-back reads with mem_en held.
      do_access(1'b1, 16'h3000, 16'hA5A5, 1'b0, 8'h00);
      do_access(1'b1, 16'h3001, 16'h5A5A, 1'b0, 8'h00);
      hold_reads(16'h3000, 16'h3001);

      // Keyboard.
      kb_pulse(8'h41);
      do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
      check_val("t3_kbsr_set", bus_if.d_out, 16'h8000);
      do_access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
      check_val("t3_kbdr", bus_if.d_out, 16'h0041);
      do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
      check_val("t3_kbsr_clr", bus_if.d_out, 16'h0000);

      // Display: second write lands while busy and is dropped.
      do_access(1'b1, 16'hFE06, 16'h0048, 1'b0, 8'h00);
      do_access(1'b1, 16'hFE06, 16'h0055, 1'b0, 8'h00);
      check_val("t4_ddr_kept", 16'(ddr_data), 16'h0048);
      for (int i = 0; i < 4; i++) do_access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);

      // MCR and reset during WAIT.
      do_access(1'b1, 16'h3010, 16'h7777, 1'b0, 8'h00);
      do_access(1'b1, 16'hFFFE, 16'h0000, 1'b0, 8'h00);
      check_val("t5_run_low", 16'(run), 16'h0);
      reset_mid_write(16'h3010, 16'hBEEF);
      do_access(1'b0, 16'h3010, 16'h0000, 1'b0, 8'h00);

      // Unmapped access.
      do_access(1'b0, 16'hC000, 16'h0000, 1'b0, 8'h00);
      check_val("t6_d_out", bus_if.d_out, 16'h0000);
      do_access(1'b0, 16'h3005, 16'h0000, 1'b0, 8'h00);

      // Randomized mix over RAM, MMIO and unmapped space.
      for (int i = 0; i < 8; i++) do_access(1'b1, 16'(16'h3020 + i), 16'($urandom), 1'b0, 8'h00);
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 9);
         d  = 16'($urandom);
         case (op)
            0, 1, 2, 3: a = 16'(16'h3020 + $urandom_range(0, 7));
            4:       a = 16'hFE00;
            5:       a = 16'hFE02;
            6:       a = 16'hFE04;
            7:       a = 16'hFE06;
            8:       a = 16'hFFFE;
            default: a = 16'($urandom_range(0, 16'h2FFF));
         endcase
         do_access(1'($urandom), a, d, (op == 5) && ($urandom_range(0, 1) == 1),
                   8'($urandom));
         if ($urandom_range(0, 3) == 0) kb_pulse(8'($urandom));
         repeat ($urandom_range(0, 4)) @(posedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 core's MAR/MDR memory handshake; services MEM.EN / R.W requests and returns the Ready bit after a programmable wait-state count.
- Contains program RAM plus LC-3 memory-mapped I/O: KBSR/KBDR for keyboard input, DSR/DDR for display output, and MCR for run control.
- Sits between the core's memory control signals and the board I/O (button/switch character source, seg display sink).

Parameters:
ADDR_W, 10, RAM depth is 2**ADDR_W words of 16 bits.
MEM_BASE, 16'h3000, first address mapped to RAM; RAM window is [MEM_BASE, MEM_BASE+2**ADDR_W).
LATENCY, 2, cycles from request acceptance to ready; legal range 1..15.
DISP_CYCLES, 8, cycles DSR[15] stays low after a DDR write; must be >= 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_en  in  1  access request (MEM.EN)
r_w  in  1  1 = write, 0 = read
addr  in  16  address from MAR
d_in  in  16  write data from MDR
d_out  out  16  read data to MDR; valid while ready=1
ready  out  1  Ready bit; one-cycle pulse per completed access
kb_strobe  in  1  one-cycle pulse, new character available
kb_data  in  8  character accompanying kb_strobe
ddr_valid  out  1  one-cycle pulse, character written to display
ddr_data  out  8  character for display; holds its value between writes
run  out  1  MCR[15], the clock-enable request to the core
mem_err  out  1  sticky unmapped-access flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async) sets: state IDLE, ready=0, d_out=0, ddr_valid=0, ddr_data=0, KBSR=0, KBDR=0, DSR=16'h8000, display counter=0, run=1, mem_err=0. RAM contents are not reset.
- FSM states are IDLE, WAIT, READY.
  - IDLE: if mem_en=1 at an edge, latch addr, r_w and d_in; load the wait counter with LATENCY-1. Go to READY if LATENCY=1, else to WAIT.
  - WAIT: decrement the counter each cycle. At 0, go to READY.
  - On the edge entering READY: commit the write or capture the read into d_out, and set ready=1.
  - READY: lasts exactly one cycle, then IDLE. d_out holds its value until the next read completes.
- Ready timing: a request accepted at edge k raises ready during the cycle after edge k+LATENCY-1. Total latency is LATENCY cycles.
- Back-to-back accesses: mem_en still high in the IDLE cycle after READY starts a new access. mem_en deasserting during WAIT does not cancel the access.
- Inputs are sampled only at acceptance; changes to addr, d_in or r_w during WAIT are ignored.
- Address decode uses the latched address. MMIO takes priority over RAM.
  - xFE00 KBSR: read returns {KBSR[15],15'b0}; writes ignored.
  - xFE02 KBDR: read returns {8'b0,KBDR}; the read clears KBSR[15] at the commit edge. Writes ignored.
  - xFE04 DSR: read returns DSR; writes ignored.
  - xFE06 DDR:
    - Read returns {8'b0,ddr_data}.
    - Write when DSR[15]=1: ddr_data=d_in[7:0]; ddr_valid pulses in the ready cycle; DSR[15]=0 and counter=DISP_CYCLES.
    - Write when DSR[15]=0: dropped, no pulse.
  - xFFFE MCR: read returns {run,15'b0}; write sets run=d_in[15].
  - RAM window: read/write word addr-MEM_BASE.
  - Any other address: read returns 0, write dropped. The access still completes with normal latency.
- Display counter decrements each cycle while nonzero. On reaching 0, DSR[15] returns to 1, so it stays low for exactly DISP_CYCLES cycles.
- Keyboard:
  - kb_strobe: KBDR=kb_data, KBSR[15]=1. A strobe with KBSR[15] already 1 overwrites KBDR.
  - kb_strobe coincident with a KBDR read commit: the new character wins and KBSR[15] stays 1. The read returns the old KBDR.
- Reset mid-access aborts the access; no write commits unless the commit edge has already occurred.

Optional Feature:
- Macro LC3_MEM_ERR_EN.
  - Defined: an access to an unmapped address sets mem_err=1 at its commit edge. mem_err stays 1 until reset.
  - Undefined: mem_err is tied 0 and no error logic is built.

Decomposition:
- Package lc3_mem_pkg: MMIO address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR), the state encoding (IDLE/WAIT/READY), and DSR/KBSR ready-bit index 15.
- One natural sub-module: lc3_mmio_regs, holding KBSR/KBDR/DSR/DDR/MCR, the display counter and the keyboard capture. The top keeps the FSM, decode and RAM array.

Test Plan:
1. LATENCY=2: write x1234 to x3005, then read x3005 -> each ready pulse arrives 2 cycles after acceptance and is 1 cycle wide; read d_out=x1234.
2. Hold mem_en high across two reads of x3000/x3001 -> two ready pulses separated by an IDLE cycle, correct data for each.
3. kb_strobe with kb_data=x41, then read KBSR, KBDR, KBSR -> returns x8000, x0041, x0000.
4. Write DDR x0048, then a second DDR write 3 cycles later with DISP_CYCLES=8 -> one ddr_valid with ddr_data=x48; the second write is dropped; DSR reads x8000 again 8 cycles after the first commit.
5. Write MCR x0000 -> run=0; assert rst=0 during WAIT of a write to x3010 -> run=1, ready=0, and x3010 is unchanged.
6. With LC3_MEM_ERR_EN, read xC000 -> d_out=0, ready pulses, mem_err=1 and stays set. Without the macro, mem_err stays 0.
